// File: rtl/reg_write_sequencer.sv
// rtl/reg_write_sequencer.sv - round-robin two-requester master for the paced two-phase 16-bit register-write port
module reg_write_sequencer #(
   parameter int NUM_REGS = 2,
   parameter int HOLD     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [3:0]  req0_addr,
   input  logic [15:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [3:0]  req1_addr,
   input  logic [15:0] req1_data,
   output logic        req1_ready,
   output logic        busy,
   output logic        done,
   output logic        done_id,
   output logic        done_err,
   output logic        enable,
   output logic        phase,
   output logic [3:0]  address,
   output logic [7:0]  reg_value
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_MSB,
      S_LSB,
      S_PHL,
      S_CLOSE,
      S_ERR
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(HOLD - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  lsb_q, lsb_d;
   logic        id_q, id_d;
   logic        last_q, last_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        done_id_q, done_id_d;
   logic        done_err_q, done_err_d;
   logic        enable_q, enable_d;
   logic        phase_q, phase_d;
   logic [3:0]  address_q, address_d;
   logic [7:0]  reg_value_q, reg_value_d;

   logic        grant0, grant1;
   logic        accept;
   logic        acc_id;
   logic [3:0]  acc_addr;
   logic [15:0] acc_data;
   logic        addr_bad;
   logic        step_end;

   // A tie goes to whichever requester was not served last; last_q resets to 0 so req1 wins the first tie.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == S_IDLE && !rst) begin
         if (req0_valid && req1_valid) begin
            grant0 = last_q;
            grant1 = !last_q;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign accept     = grant0 | grant1;
   assign acc_id     = grant1;
   assign acc_addr   = grant1 ? req1_addr : req0_addr;
   assign acc_data   = grant1 ? req1_data : req0_data;
   assign addr_bad   = ({28'd0, acc_addr} >= 32'(NUM_REGS));
   assign step_end   = (cnt_q == 4'd0);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lsb_d       = lsb_q;
      id_d        = id_q;
      last_d      = last_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      done_id_d   = 1'b0;
      done_err_d  = 1'b0;
      enable_d    = enable_q;
      phase_d     = phase_q;
      address_d   = address_q;
      reg_value_d = reg_value_q;

      if (state_q != S_IDLE && state_q != S_ERR && !step_end) begin
         cnt_d = cnt_q - 4'd1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               lsb_d  = acc_data[7:0];
               id_d   = acc_id;
               last_d = acc_id;
               busy_d = 1'b1;
               if (addr_bad) begin
                  state_d = S_ERR;
               end else begin
                  state_d     = S_ARM;
                  cnt_d       = CNT_LOAD;
                  phase_d     = 1'b1;
                  address_d   = acc_addr;
                  reg_value_d = acc_data[15:8];
               end
            end
         end
         S_ARM: begin
            if (step_end) begin
               state_d  = S_MSB;
               cnt_d    = CNT_LOAD;
               enable_d = 1'b1;
            end
         end
         S_MSB: begin
            if (step_end) begin
               state_d     = S_LSB;
               cnt_d       = CNT_LOAD;
               reg_value_d = lsb_q;
            end
         end
         S_LSB: begin
            if (step_end) begin
               state_d = S_PHL;
               cnt_d   = CNT_LOAD;
               phase_d = 1'b0;
            end
         end
         S_PHL: begin
            if (step_end) begin
               state_d  = S_CLOSE;
               cnt_d    = CNT_LOAD;
               enable_d = 1'b0;
            end
         end
         S_CLOSE: begin
            if (step_end) begin
               state_d   = S_IDLE;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               done_id_d = id_q;
            end
         end
         S_ERR: begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            done_id_d  = id_q;
            done_err_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         lsb_q       <= 8'd0;
         id_q        <= 1'b0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         done_id_q   <= 1'b0;
         done_err_q  <= 1'b0;
         enable_q    <= 1'b0;
         phase_q     <= 1'b0;
         address_q   <= 4'd0;
         reg_value_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lsb_q       <= lsb_d;
         id_q        <= id_d;
         last_q      <= last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         done_id_q   <= done_id_d;
         done_err_q  <= done_err_d;
         enable_q    <= enable_d;
         phase_q     <= phase_d;
         address_q   <= address_d;
         reg_value_q <= reg_value_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign done_id   = done_id_q;
   assign done_err  = done_err_q;
   assign enable    = enable_q;
   assign phase     = phase_q;
   assign address   = address_q;
   assign reg_value = reg_value_q;

endmodule

// File: tb/tb_reg_write_sequencer.sv
// tb/tb_reg_write_sequencer.sv - scoreboard bench for reg_write_sequencer at HOLD=4 (index 0) and HOLD=3 (index 1)
module tb_reg_write_sequencer;

   localparam int NR = 2;

   typedef struct {
      logic        id;
      logic        err;
      logic [3:0]  addr;
      logic [15:0] data;
      int          hs;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst   [2];
   logic        r0v   [2];
   logic [3:0]  r0a   [2];
   logic [15:0] r0d   [2];
   logic        r0rdy [2];
   logic        r1v   [2];
   logic [3:0]  r1a   [2];
   logic [15:0] r1d   [2];
   logic        r1rdy [2];
   logic        busy  [2];
   logic        done  [2];
   logic        did   [2];
   logic        derr  [2];
   logic        en    [2];
   logic        ph    [2];
   logic [3:0]  adr   [2];
   logic [7:0]  rv    [2];

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t sb [2][$];
   logic last_m [2];
   int   ndone [2];
   int   ncommit [2];
   logic rx_clr;

   logic [15:0] rx [2][NR];
   logic [2:0]  en_sh [2];
   logic [2:0]  ph_sh [2];
   logic [7:0]  msb_l [2];
   logic [7:0]  lsb_l [2];
   logic        lsb_ok [2];

   exp_t mon_e;
   logic mon_id;

   reg_write_sequencer #(.NUM_REGS(NR), .HOLD(4)) u_dut4 (
      .clk(clk), .rst(rst[0]),
      .req0_valid(r0v[0]), .req0_addr(r0a[0]), .req0_data(r0d[0]), .req0_ready(r0rdy[0]),
      .req1_valid(r1v[0]), .req1_addr(r1a[0]), .req1_data(r1d[0]), .req1_ready(r1rdy[0]),
      .busy(busy[0]), .done(done[0]), .done_id(did[0]), .done_err(derr[0]),
      .enable(en[0]), .phase(ph[0]), .address(adr[0]), .reg_value(rv[0])
   );

   reg_write_sequencer #(.NUM_REGS(NR), .HOLD(3)) u_dut3 (
      .clk(clk), .rst(rst[1]),
      .req0_valid(r0v[1]), .req0_addr(r0a[1]), .req0_data(r0d[1]), .req0_ready(r0rdy[1]),
      .req1_valid(r1v[1]), .req1_addr(r1a[1]), .req1_data(r1d[1]), .req1_ready(r1rdy[1]),
      .busy(busy[1]), .done(done[1]), .done_id(did[1]), .done_err(derr[1]),
      .enable(en[1]), .phase(ph[1]), .address(adr[1]), .reg_value(rv[1])
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Receiver: 2-flop synchronizers plus edge detect; commit only after the LSB phase fall was seen.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rx_clr) begin
            en_sh[k]   <= 3'd0;
            ph_sh[k]   <= 3'd0;
            msb_l[k]   <= 8'd0;
            lsb_l[k]   <= 8'd0;
            lsb_ok[k]  <= 1'b0;
            ncommit[k] <= 0;
            for (int j = 0; j < NR; j++) rx[k][j] <= 16'd0;
         end else begin
            en_sh[k] <= {en_sh[k][1:0], en[k]};
            ph_sh[k] <= {ph_sh[k][1:0], ph[k]};
            if (en_sh[k][1] && !en_sh[k][2]) begin
               msb_l[k]  <= rv[k];
               lsb_ok[k] <= 1'b0;
            end
            if (!ph_sh[k][1] && ph_sh[k][2]) begin
               lsb_l[k]  <= rv[k];
               lsb_ok[k] <= 1'b1;
            end
            if (!en_sh[k][1] && en_sh[k][2] && lsb_ok[k]) begin
               if ({28'd0, adr[k]} < 32'(NR)) rx[k][adr[k][0]] <= {msb_l[k], lsb_l[k]};
               ncommit[k] <= ncommit[k] + 1;
               lsb_ok[k]  <= 1'b0;
            end
         end
      end
   end

   // Scoreboard: push on handshake, pop and compare on done.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst[k]) begin
            last_m[k] = 1'b0;
         end else begin
            if (done[k]) begin
               ndone[k]++;
               if (sb[k].size() == 0) begin
                  chk("done_without_request", 32'(done[k]), 32'd0);
               end else begin
                  mon_e = sb[k].pop_front();
                  chk("done_id", 32'(did[k]), 32'(mon_e.id));
                  chk("done_err", 32'(derr[k]), 32'(mon_e.err));
                  chk("done_latency", 32'(cyc - mon_e.hs),
                      mon_e.err ? 32'd2 : ((k == 0) ? 32'd21 : 32'd16));
                  if (!mon_e.err) chk("rx_commit", 32'(rx[k][mon_e.addr[0]]), 32'(mon_e.data));
               end
            end
            if (r0rdy[k] || r1rdy[k]) begin
               mon_id = (r0v[k] && r1v[k]) ? !last_m[k] : r1v[k];
               chk("grant", 32'({r1rdy[k], r0rdy[k]}), mon_id ? 32'd2 : 32'd1);
               last_m[k]  = mon_id;
               mon_e.id   = mon_id;
               mon_e.addr = mon_id ? r1a[k] : r0a[k];
               mon_e.data = mon_id ? r1d[k] : r0d[k];
               mon_e.err  = ({28'd0, mon_e.addr} >= 32'(NR));
               mon_e.hs   = cyc;
               sb[k].push_back(mon_e);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_hs(input int k, output logic id);
      bit seen;
      seen = 1'b0;
      id   = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if ((r0v[k] && r0rdy[k]) || (r1v[k] && r1rdy[k])) begin
            seen = 1'b1;
            id   = r1v[k] && r1rdy[k];
         end
      end
      chk("handshake_seen", 32'(seen), 32'd1);
   endtask

   task automatic wait_done(input int k);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (done[k]) seen = 1'b1;
      end
      chk("done_seen", 32'(seen), 32'd1);
   endtask

   initial begin
      logic id;
      logic act;
      int   c0;
      int   c1;
      int   t0;

      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1;
         r0v[k] = 1'b0; r0a[k] = 4'd0; r0d[k] = 16'd0;
         r1v[k] = 1'b0; r1a[k] = 4'd0; r1d[k] = 16'd0;
      end
      rx_clr = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rx_clr = 1'b0;
      rst[0] = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("reset_outputs", 32'({en[k], ph[k], busy[k], done[k], did[k], derr[k],
                                   r0rdy[k], r1rdy[k], adr[k], rv[k]}), 32'd0);
      end

      // single write, HOLD=4: 0xA5C3 -> addr 1 from req0
      @(posedge clk); #1;
      r0v[0] = 1'b1; r0a[0] = 4'd1; r0d[0] = 16'hA5C3;
      wait_hs(0, id);
      chk("w1_id", 32'(id), 32'd0);
      @(posedge clk); #1 r0v[0] = 1'b0;
      @(negedge clk);
      chk("t1_phase", 32'(ph[0]), 32'd1);
      chk("t1_value", 32'(rv[0]), 32'hA5);
      chk("t1_addr", 32'(adr[0]), 32'd1);
      chk("t1_enable", 32'(en[0]), 32'd0);
      chk("t1_busy", 32'(busy[0]), 32'd1);
      tick(3);
      chk("t4_enable", 32'(en[0]), 32'd0);
      tick(1);
      chk("t5_enable", 32'(en[0]), 32'd1);
      tick(3);
      chk("t8_value", 32'(rv[0]), 32'hA5);
      tick(1);
      chk("t9_value", 32'(rv[0]), 32'hC3);
      chk("t9_phase", 32'(ph[0]), 32'd1);
      tick(3);
      chk("t12_phase", 32'(ph[0]), 32'd1);
      tick(1);
      chk("t13_phase", 32'(ph[0]), 32'd0);
      chk("t13_enable", 32'(en[0]), 32'd1);
      tick(4);
      chk("t17_enable", 32'(en[0]), 32'd0);
      chk("t17_addr", 32'(adr[0]), 32'd1);
      tick(3);
      chk("t20_done", 32'(done[0]), 32'd0);
      chk("t20_busy", 32'(busy[0]), 32'd1);
      tick(1);
      chk("t21_done", 32'({done[0], did[0], derr[0], busy[0]}), 32'b1000);
      chk("w1_rx1", 32'(rx[0][1]), 32'hA5C3);
      tick(1);
      chk("t22_done", 32'(done[0]), 32'd0);

      // both requesters valid from reset: alternate 1,0,1,0, each grant in the previous done cycle
      @(posedge clk); #1;
      rst[0] = 1'b1;
      sb[0].delete();
      r0v[0] = 1'b1; r0a[0] = 4'd0; r0d[0] = 16'h1111;
      r1v[0] = 1'b1; r1a[0] = 4'd1; r1d[0] = 16'h2222;
      @(posedge clk); #1 rst[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_hs(0, id);
         chk("rr_alternate", 32'(id), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("b2b_done_cycle", 32'(done[0]), (i > 0) ? 32'd1 : 32'd0);
      end
      @(posedge clk); #1;
      r0v[0] = 1'b0;
      r1v[0] = 1'b0;
      wait_done(0);
      chk("rr_rx0", 32'(rx[0][0]), 32'h1111);
      chk("rr_rx1", 32'(rx[0][1]), 32'h2222);

      // out-of-range address from req1
      c0 = ncommit[0];
      @(posedge clk); #1;
      r1v[0] = 1'b1; r1a[0] = 4'd5; r1d[0] = 16'h1234;
      wait_hs(0, id);
      @(posedge clk); #1 r1v[0] = 1'b0;
      @(negedge clk);
      chk("err_t1", 32'({busy[0], done[0], en[0]}), 32'b100);
      @(negedge clk);
      chk("err_t2", 32'({busy[0], done[0], derr[0], did[0], en[0]}), 32'b01110);
      tick(5);
      chk("err_no_commit", 32'(ncommit[0]), 32'(c0));
      chk("err_rx0", 32'(rx[0][0]), 32'h1111);
      chk("err_rx1", 32'(rx[0][1]), 32'h2222);

      // reset pulse while in MSB, then a normal write
      @(posedge clk); #1;
      r0v[0] = 1'b1; r0a[0] = 4'd0; r0d[0] = 16'h5A5A;
      wait_hs(0, id);
      @(posedge clk); #1 r0v[0] = 1'b0;
      tick(6);
      chk("msb_enable", 32'(en[0]), 32'd1);
      c1 = ndone[0];
      @(posedge clk); #1;
      rst[0] = 1'b1;
      sb[0].delete();
      @(posedge clk); #1 rst[0] = 1'b0;
      @(negedge clk);
      chk("rst_outputs", 32'({en[0], ph[0], busy[0], done[0], did[0], derr[0], adr[0], rv[0]}), 32'd0);
      tick(30);
      chk("rst_no_done", 32'(ndone[0]), 32'(c1));
      chk("rst_no_commit", 32'(ncommit[0]), 32'(c0));
      chk("rst_rx0", 32'(rx[0][0]), 32'h1111);
      @(posedge clk); #1;
      r0v[0] = 1'b1; r0a[0] = 4'd0; r0d[0] = 16'h00FF;
      wait_hs(0, id);
      @(posedge clk); #1 r0v[0] = 1'b0;
      wait_done(0);
      chk("post_rst_rx0", 32'(rx[0][0]), 32'h00FF);

      // req0 pulses valid for one cycle while busy, then withdraws
      @(posedge clk); #1;
      r1v[0] = 1'b1; r1a[0] = 4'd1; r1d[0] = 16'h3C3C;
      wait_hs(0, id);
      @(posedge clk); #1 r1v[0] = 1'b0;
      tick(5);
      @(posedge clk); #1;
      r0v[0] = 1'b1; r0a[0] = 4'd0; r0d[0] = 16'h7777;
      @(negedge clk);
      chk("busy_no_ready", 32'(r0rdy[0]), 32'd0);
      @(posedge clk); #1 r0v[0] = 1'b0;
      wait_done(0);
      chk("pulse_rx1", 32'(rx[0][1]), 32'h3C3C);
      act = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         act = act | busy[0] | en[0] | ph[0] | r0rdy[0] | r1rdy[0] | done[0];
      end
      chk("withdraw_no_activity", 32'(act), 32'd0);
      chk("withdraw_rx0", 32'(rx[0][0]), 32'h00FF);

      // HOLD=3 back-to-back writes
      r0v[1] = 1'b1; r0a[1] = 4'd0; r0d[1] = 16'hBEEF;
      r1v[1] = 1'b1; r1a[1] = 4'd1; r1d[1] = 16'hCAFE;
      @(posedge clk); #1 rst[1] = 1'b0;
      wait_hs(1, id);
      chk("h3_first_grant", 32'(id), 32'd1);
      @(posedge clk); #1 r1v[1] = 1'b0;
      wait_hs(1, id);
      chk("h3_second_grant", 32'(id), 32'd0);
      chk("h3_grant_in_done", 32'(done[1]), 32'd1);
      t0 = cyc;
      @(posedge clk); #1 r0v[1] = 1'b0;
      wait_done(1);
      chk("h3_done_spacing", 32'(cyc - t0), 32'd16);
      chk("h3_rx0", 32'(rx[1][0]), 32'hBEEF);
      chk("h3_rx1", 32'(rx[1][1]), 32'hCAFE);
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
